bd_funnel_decoder: RTL and testbench
====================================

// Module: bd_funnel_decoder
// PURPOSE
//  Return path for the BD funnel encoder: takes route-coded words from BD's output horn, decodes the LSB-first route prefix to a leaf code and extracts the payload.
//  It reassembles the 4-chunk serialized dump leaves, then re-splits each into 2 words for the PC.
//  Sits between the BD output pins/synchronizer and the upstream packetizer.
// PARAMETERS
//  NBDin     24  BD output word width (route in LSBs, payload above)
//  Npayload  24  output payload width
//  Ncode      6  leaf code width
// PORTS
//  clk                  in   1         system clock
//  reset                in   1         synchronous, active-low reset
//  BD_data_in_v         in   1         BD word valid
//  BD_data_in_d         in   NBDin     BD word {payload, route}
//  BD_data_in_a         out  1         BD word ack
//  words_out_v          out  1         decoded word valid
//  words_out_leaf_code  out  Ncode     leaf code
//  words_out_payload    out  Npayload  payload, zero-extended
//  words_out_a          in   1         decoded word ack
//  partial_dump         out  3         bit k=1: leaf 5+k holds 1..3 buffered chunks
// BEHAVIOUR
//  Channels: transfer when v&a in the same cycle. An ack is asserted only while valid is high. Ack is combinational from state and words_out_a.
//  Route table (bits[len-1:0] of d), leaf code and name, len, and chunk width C for serialized leaves:
//   0 ->0 NRN_OUT | 01 ->1 ACC_OUT | 011 ->2 TAT_OUT | 00111 ->3 PRE_FIFO_DUMP | 10111 ->4 POST_FIFO_DUMP
//   001111 ->5 DUMP_AM C=11 | 101111 ->6 DUMP_PAT C=7 | 011111 ->7 DUMP_TAT C=8 | 111111 ->8 OVFLW
//   The code is complete and prefix-free. Every word decodes, so there is no error path.
//  Payload = d >> len, zero-filled. Serialized leaves use payload[C-1:0] only; upper bits are ignored.
//  Non-serialized leaf: one output word. Latency is 1 cycle (accept at edge N, words_out_v high after edge N).
//  Serialized leaf k:
//   - Each leaf has its own 2-bit chunk counter and a 4C-bit buffer. Chunk i goes to buf[i*C +: C]; chunk 0 is LSBs.
//   - Chunks of different leaves, and other traffic, may interleave freely.
//   - Chunks 0-2 are stored only and produce no output.
//   - Chunk 3: output reg loads LO = buf[0 +: 2C] and HI = buf[2C +: 2C], both with leaf code k. Counter returns to 0.
//  FSM: PASS, HI.
//   PASS: accept chunks 0-2 unconditionally. Accept other words when !words_out_v | words_out_a.
//    On accepting chunk 3, load LO into the output reg and go to HI.
//   HI: BD_data_in_a=0. When LO is acked, load HI into the output reg and go to PASS.
//  Throughput: 1 word/cycle when an output ack and a new input occur in the same cycle. The output reg holds until acked (no drops).
//  Backpressure: out v held high, leaf code and payload held stable.
//  Reset (low at an edge) sets words_out_v=0, BD_data_in_a=0, all counters and buffers to 0, partial_dump=0, FSM=PASS.
//  Partial dumps and pending HI are discarded, including when reset arrives mid-operation.
//  partial_dump[k] = (counter of leaf 5+k != 0). It is registered.
// TESTING
//  1. d=(12'hABC<<1)|1'b0 -> one cycle later leaf 0, payload 24'h000ABC, single word.
//  2. d=(22'h2F00F<<2)|2'b01 -> leaf 1, payload 24'h02F00F.
//  3. AM chunks 1,2,3,4 (11-bit) -> leaf 5 payload 24'h001001, then 24'h002003. BD ack low for 1 cycle during HI.
//  4. PAT c0,c1, then NRN word, then PAT c2,c3 -> NRN emitted first, then PAT LO, then HI. partial_dump[1]=1 between c0 and c3.
//  5. words_out_a=0 for 5 cycles with out valid -> outputs stable. NRN word not acked. TAT chunk 0 still acked.
//  6. 2 AM chunks, reset low for 1 cycle, then 4 fresh chunks -> exactly one LO/HI pair built only from fresh data.

Source files
------------

// File: rtl/bd_funnel_decoder.sv
// bd_funnel_decoder: decodes route-coded BD words and rebuilds serialized dumps
module bd_funnel_decoder #(
  parameter int NBDin    = 24,
  parameter int Npayload = 24,
  parameter int Ncode    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                BD_data_in_v,
  input  logic [NBDin-1:0]    BD_data_in_d,
  output logic                BD_data_in_a,
  output logic                words_out_v,
  output logic [Ncode-1:0]    words_out_leaf_code,
  output logic [Npayload-1:0] words_out_payload,
  input  logic                words_out_a,
  output logic [2:0]          partial_dump
);
  typedef enum logic {PASS, HI} state_t;
  state_t state, state_d;
  logic [3:0] leaf;
  logic [2:0] len;
  logic [NBDin-1:0] pay;
  logic ser, last, out_free;
  logic [1:0] idx;
  logic [2:0][1:0] cnt, cnt_d;
  logic [43:0] am_q;
  logic [27:0] pat_q;
  logic [31:0] tat_q;
  logic [Npayload-1:0] lo, hi;
  always_comb begin
    leaf = !BD_data_in_d[0] ? 4'd0 : !BD_data_in_d[1] ? 4'd1 : !BD_data_in_d[2] ? 4'd2 :
           !BD_data_in_d[3] ? (BD_data_in_d[4] ? 4'd4 : 4'd3) :
           BD_data_in_d[4] ? (BD_data_in_d[5] ? 4'd8 : 4'd7) : (BD_data_in_d[5] ? 4'd6 : 4'd5);
    len = leaf == 4'd0 ? 3'd1 : leaf == 4'd1 ? 3'd2 : leaf == 4'd2 ? 3'd3 : leaf < 4'd5 ? 3'd5 : 3'd6;
    pay = BD_data_in_d >> len;
    ser = leaf >= 4'd5 && leaf <= 4'd7;
    idx = ser ? 2'(leaf - 4'd5) : 2'd0;
    last = ser && cnt[idx] == 2'd3;
    out_free = !words_out_v || words_out_a;
    // chunks 0-2 never touch the output reg, so they bypass output backpressure
    BD_data_in_a = reset && BD_data_in_v && state == PASS && ((ser && !last) || out_free);
    state_d = state;
    if (state == PASS && BD_data_in_a && last) state_d = HI;
    if (state == HI && words_out_a) state_d = PASS;
    cnt_d = cnt;
    if (BD_data_in_a && ser) cnt_d[idx] = cnt[idx] + 2'd1;
    lo = leaf == 4'd5 ? Npayload'(am_q[21:0]) : leaf == 4'd6 ? Npayload'(pat_q[13:0]) : Npayload'(tat_q[15:0]);
    hi = words_out_leaf_code == Ncode'(5) ? Npayload'(am_q[43:22]) :
         words_out_leaf_code == Ncode'(6) ? Npayload'(pat_q[27:14]) : Npayload'(tat_q[31:16]);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= PASS;
      cnt <= '0;
      partial_dump <= '0;
      am_q <= '0;
      pat_q <= '0;
      tat_q <= '0;
      words_out_v <= 1'b0;
      words_out_leaf_code <= '0;
      words_out_payload <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      partial_dump <= {cnt_d[2] != 2'd0, cnt_d[1] != 2'd0, cnt_d[0] != 2'd0};
      if (BD_data_in_a && leaf == 4'd5) am_q[cnt[0]*11 +: 11] <= pay[10:0];
      if (BD_data_in_a && leaf == 4'd6) pat_q[cnt[1]*7 +: 7] <= pay[6:0];
      if (BD_data_in_a && leaf == 4'd7) tat_q[cnt[2]*8 +: 8] <= pay[7:0];
      if (words_out_v && words_out_a) words_out_v <= 1'b0;
      // HI comes from the buffer: input is blocked in HI, so it cannot change
      if (state == HI && words_out_a) begin
        words_out_v <= 1'b1;
        words_out_payload <= hi;
      end else if (BD_data_in_a && (!ser || last)) begin
        words_out_v <= 1'b1;
        words_out_leaf_code <= Ncode'(leaf);
        words_out_payload <= ser ? lo : Npayload'(pay);
      end
    end
  end
endmodule

// File: tb/tb_bd_funnel_decoder.sv
// tb_bd_funnel_decoder: randomized and directed checks against a route-table reference model
module tb_bd_funnel_decoder;
  logic clk, rst_n, in_v, in_a, out_v, out_a;
  logic [23:0] in_d, out_pay;
  logic [5:0] out_code;
  logic [2:0] pdump;
  int checks = 0, errors = 0, n_out = 0;
  int codes[9] = '{0, 1, 3, 7, 23, 15, 47, 31, 63};
  int lens[9] = '{1, 2, 3, 5, 5, 6, 6, 6, 6};
  int cw[3] = '{11, 7, 8};
  int unsigned chv[3][4];
  int cntm[3];
  int unsigned exp_code[$], exp_pay[$];
  bit hold, last_in_a;
  logic [5:0] h_c;
  logic [23:0] h_p;

  bd_funnel_decoder dut (
    .clk(clk), .reset(rst_n),
    .BD_data_in_v(in_v), .BD_data_in_d(in_d), .BD_data_in_a(in_a),
    .words_out_v(out_v), .words_out_leaf_code(out_code), .words_out_payload(out_pay),
    .words_out_a(out_a), .partial_dump(pdump)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] mk(input int leaf, input logic [23:0] r);
    return (r << lens[leaf]) | 24'(codes[leaf]);
  endfunction

  function automatic void model_accept(input logic [23:0] d);
    int leaf = 0, k, c;
    int unsigned p;
    for (int i = 0; i < 9; i++)
      if ((int'(d) & ((1 << lens[i]) - 1)) == codes[i]) leaf = i;
    p = int'(d) >> lens[leaf];
    if (leaf >= 5 && leaf <= 7) begin
      k = leaf - 5;
      c = cw[k];
      chv[k][cntm[k]] = p & ((1 << c) - 1);
      cntm[k]++;
      if (cntm[k] == 4) begin
        exp_code.push_back(leaf); exp_pay.push_back(chv[k][0] + (chv[k][1] << c));
        exp_code.push_back(leaf); exp_pay.push_back(chv[k][2] + (chv[k][3] << c));
        cntm[k] = 0;
      end
    end else begin
      exp_code.push_back(leaf); exp_pay.push_back(p);
    end
  endfunction

  task automatic step(input bit v, input logic [23:0] d, input bit oa);
    int unsigned ec, ep;
    logic [2:0] mp;
    @(negedge clk);
    in_v = v; in_d = d; out_a = oa && out_v;
    #4;
    last_in_a = in_a;
    checks++;
    if (in_a && !in_v) begin errors++; $display("FAIL ack_without_valid: ack=%0b valid=%0b", in_a, in_v); end
    if (out_v && out_a) begin
      n_out++;
      checks++;
      if (exp_code.size() == 0) begin
        errors++; $display("FAIL out_unexpected: got code=%0d payload=%h, expected no word", out_code, out_pay);
      end else begin
        ec = exp_code.pop_front(); ep = exp_pay.pop_front();
        if (out_code !== 6'(ec) || out_pay !== 24'(ep)) begin
          errors++; $display("FAIL out_word: got code=%0d payload=%h, expected code=%0d payload=%h", out_code, out_pay, ec, ep);
        end
      end
    end
    hold = out_v && !out_a; h_c = out_code; h_p = out_pay;
    if (in_v && in_a) model_accept(d);
    @(posedge clk); #1;
    mp = {cntm[2] != 0, cntm[1] != 0, cntm[0] != 0};
    checks++;
    if (pdump !== mp) begin errors++; $display("FAIL partial_dump: got %b, expected %b", pdump, mp); end
    if (hold) begin
      checks++;
      if (out_v !== 1'b1 || out_code !== h_c || out_pay !== h_p) begin
        errors++; $display("FAIL out_hold: got v=%0b code=%0d payload=%h, expected v=1 code=%0d payload=%h", out_v, out_code, out_pay, h_c, h_p);
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 0; in_v = 1; in_d = mk(0, 24'h55); out_a = 0;
    #4;
    checks++;
    if (in_a !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, expected 0", in_a); end
    @(posedge clk); #1;
    checks++;
    if (out_v !== 1'b0 || pdump !== 3'b0) begin errors++; $display("FAIL reset_state: got v=%b pdump=%b, expected v=0 pdump=000", out_v, pdump); end
    @(negedge clk);
    rst_n = 1; in_v = 0;
    for (int i = 0; i < 3; i++) cntm[i] = 0;
    exp_code.delete(); exp_pay.delete();
    hold = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_v = 0; in_d = 0; out_a = 0; hold = 0;
    for (int i = 0; i < 3; i++) cntm[i] = 0;
    repeat (2) @(posedge clk);
    reset_pulse();
  endtask

  task automatic test_single();
    step(1, (24'hABC << 1) | 24'd0, 0);
    checks++;
    if (out_v !== 1'b1 || out_code !== 6'd0 || out_pay !== 24'h000ABC) begin
      errors++; $display("FAIL nrn_word: got v=%b code=%0d payload=%h, expected v=1 code=0 payload=000abc", out_v, out_code, out_pay);
    end
    step(0, 0, 1);
    checks++;
    if (out_v !== 1'b0) begin errors++; $display("FAIL nrn_single: got v=%b, expected 0", out_v); end
    step(1, (24'h2F00F << 2) | 24'd1, 1);
    checks++;
    if (out_code !== 6'd1 || out_pay !== 24'h02F00F) begin
      errors++; $display("FAIL acc_word: got code=%0d payload=%h, expected code=1 payload=02f00f", out_code, out_pay);
    end
    step(0, 0, 1);
  endtask

  task automatic test_am_dump();
    for (int k = 1; k <= 4; k++) step(1, (24'(k) << 6) | 24'd15, 1);
    checks++;
    if (out_v !== 1'b1 || out_code !== 6'd5 || out_pay !== 24'h001001) begin
      errors++; $display("FAIL am_lo: got v=%b code=%0d payload=%h, expected v=1 code=5 payload=001001", out_v, out_code, out_pay);
    end
    step(1, mk(0, 24'h1), 1);
    checks++;
    if (last_in_a !== 1'b0) begin errors++; $display("FAIL hi_ack: got %b, expected 0", last_in_a); end
    checks++;
    if (out_v !== 1'b1 || out_code !== 6'd5 || out_pay !== 24'h002003) begin
      errors++; $display("FAIL am_hi: got v=%b code=%0d payload=%h, expected v=1 code=5 payload=002003", out_v, out_code, out_pay);
    end
    step(1, mk(0, 24'h1), 1);
    checks++;
    if (last_in_a !== 1'b1) begin errors++; $display("FAIL post_hi_ack: got %b, expected 1", last_in_a); end
    step(0, 0, 1);
  endtask

  task automatic test_interleave();
    logic [6:0] c[4] = '{7'h11, 7'h22, 7'h33, 7'h44};
    step(1, mk(6, {11'h5A5, c[0]}), 1);
    checks++;
    if (pdump[1] !== 1'b1) begin errors++; $display("FAIL pat_partial: got %b, expected 1", pdump[1]); end
    step(1, mk(6, {11'h2F0, c[1]}), 1);
    step(1, mk(0, 24'h123), 1);
    checks++;
    if (out_code !== 6'd0 || out_pay !== 24'h000123) begin
      errors++; $display("FAIL pat_nrn_first: got code=%0d payload=%h, expected code=0 payload=000123", out_code, out_pay);
    end
    step(1, mk(6, {11'h7FF, c[2]}), 1);
    step(1, mk(6, {11'h001, c[3]}), 1);
    checks++;
    if (out_code !== 6'd6 || out_pay !== (24'(c[0]) | (24'(c[1]) << 7)) || pdump[1] !== 1'b0) begin
      errors++; $display("FAIL pat_lo: got code=%0d payload=%h pdump=%b, expected code=6 payload=%h pdump[1]=0", out_code, out_pay, pdump, 24'(c[0]) | (24'(c[1]) << 7));
    end
    step(0, 0, 1);
    checks++;
    if (out_code !== 6'd6 || out_pay !== (24'(c[2]) | (24'(c[3]) << 7))) begin
      errors++; $display("FAIL pat_hi: got code=%0d payload=%h, expected code=6 payload=%h", out_code, out_pay, 24'(c[2]) | (24'(c[3]) << 7));
    end
    step(0, 0, 1);
  endtask

  task automatic test_backpressure();
    step(1, mk(0, 24'h777), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, mk(0, 24'h888), 0);
      checks++;
      if (last_in_a !== 1'b0) begin errors++; $display("FAIL stall_nrn_ack: got %b, expected 0", last_in_a); end
    end
    step(1, mk(7, 24'h5A), 0);
    checks++;
    if (last_in_a !== 1'b1) begin errors++; $display("FAIL stall_tat_ack: got %b, expected 1", last_in_a); end
    step(0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step(1, mk(i % 3, 24'($urandom)), 1);
      checks++;
      if (last_in_a !== 1'b1 || out_v !== 1'b1) begin
        errors++; $display("FAIL b2b: got ack=%b v=%b, expected ack=1 v=1", last_in_a, out_v);
      end
    end
    step(0, 0, 1);
  endtask

  task automatic test_reset_mid_dump();
    int n0;
    step(1, mk(5, 24'h7FF), 1);
    step(1, mk(5, 24'h3FF), 1);
    checks++;
    if (pdump[0] !== 1'b1) begin errors++; $display("FAIL am_partial: got %b, expected 1", pdump[0]); end
    reset_pulse();
    n0 = n_out;
    for (int k = 0; k < 4; k++) step(1, mk(5, 24'(k * 100 + 9)), 1);
    repeat (4) step(0, 0, 1);
    checks++;
    if (n_out - n0 != 2) begin errors++; $display("FAIL reset_pair_count: got %0d, expected 2", n_out - n0); end
  endtask

  task automatic test_random();
    int leaf;
    for (int i = 0; i < 3000; i++) begin
      leaf = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 7) : $urandom_range(0, 8);
      step($urandom_range(0, 9) < 7, mk(leaf, 24'($urandom)), $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 20 && (exp_code.size() != 0 || out_v); i++) step(0, 0, 1);
    checks++;
    if (exp_code.size() != 0 || out_v !== 1'b0) begin
      errors++; $display("FAIL drain: got %0d words pending v=%b, expected 0 pending v=0", exp_code.size(), out_v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_am_dump();
    test_interleave();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_dump();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
